// File: rtl/mul_seq_pkg.sv
// Shared encodings, state names and arithmetic helpers for the multiplier cell sequencer.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISS0  = 3'd1,
    ST_ISS1  = 3'd2,
    ST_ISS2  = 3'd3,
    ST_ISS3  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_FIX   = 3'd6,
    ST_RESP  = 3'd7
  } state_t;

  // Left shift applied to each 16x16 partial product before accumulation.
  localparam int SH_LL = 0;
  localparam int SH_LH = 16;
  localparam int SH_HL = 16;
  localparam int SH_HH = 32;

  // Place a 32-bit partial product into the 64-bit accumulator frame.
  function automatic logic [63:0] place_product(input logic [31:0] p, input int sh);
    place_product = {32'd0, p} << sh;
  endfunction

  // Turn the unsigned high word into the signed/mixed high word.
  function automatic logic [31:0] fix_high(input op_t op, input logic [31:0] hi,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = hi;
    case (op)
      OP_MULXSU: begin
        if (a[31]) r = r - b;
        else       r = hi;
      end
      OP_MULXSS: begin
        if (a[31]) r = r - b;
        else       r = hi;
        if (b[31]) r = r - a;
        else       r = r;
      end
      default: r = hi;
    endcase
    fix_high = r;
  endfunction

endpackage

// File: rtl/mul_seq_rr_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer.
module mul_seq_rr_arb
  import mul_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic           found;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) next_ptr = '0;
    else                          next_ptr = idx + IDW'(1);
  endfunction

  // Search requesters in rotating order starting at the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Move the pointer past the requester that just won.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr(grant_idx);
    end
  end

endmodule

// File: rtl/mul_cell_sequencer.sv
// Shares one registered 16x16 multiplier cell between requesters to build 32x32 products.
module mul_cell_sequencer
  import mul_seq_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_src1,
  input  logic [32*NUM_REQ-1:0]   req_src2,
  output logic [15:0]             mul_a,
  output logic [15:0]             mul_b,
  output logic                    mul_en,
  input  logic [31:0]             mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [31:0]             rsp_data
);

  state_t         state;
  op_t            op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic [IDW-1:0] id_q;
  logic [63:0]    acc;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               arb_en;
  logic               take;
  op_t                sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [31:0]        hi_fixed;

  // Grants are only offered while idle and out of reset.
  assign arb_en    = (state == ST_IDLE) && reset_n;
  assign req_ready = grant;
  assign take      = |(req_valid & grant);
  assign hi_fixed  = fix_high(op_q, acc[63:32], a_q, b_q);

  mul_seq_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .enable    (arb_en),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Select the winning requester's op and operands for latching.
  always_comb begin
    sel_op = op_t'(req_op[int'(grant_idx)*2 +: 2]);
    sel_a  = req_src1[int'(grant_idx)*32 +: 32];
    sel_b  = req_src2[int'(grant_idx)*32 +: 32];
  end

  // Sequencer FSM: issue partial products, accumulate one cycle later, fix sign, respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MUL;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      id_q      <= '0;
      acc       <= 64'd0;
      mul_a     <= 16'd0;
      mul_b     <= 16'd0;
      mul_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= grant_idx;
            acc    <= 64'd0;
            mul_en <= 1'b1;
            mul_a  <= sel_a[15:0];
            mul_b  <= sel_b[15:0];
            state  <= ST_ISS0;
          end
        end
        ST_ISS0: begin
          mul_a <= a_q[15:0];
          mul_b <= b_q[31:16];
          state <= ST_ISS1;
        end
        ST_ISS1: begin
          acc   <= acc + place_product(mul_p, SH_LL);
          mul_a <= a_q[31:16];
          mul_b <= b_q[15:0];
          state <= ST_ISS2;
        end
        ST_ISS2: begin
          acc <= acc + place_product(mul_p, SH_LH);
          // The low word never needs the HH product.
          if (op_q == OP_MUL) begin
            mul_en <= 1'b0;
            mul_a  <= 16'd0;
            mul_b  <= 16'd0;
            state  <= ST_DRAIN;
          end else begin
            mul_a  <= a_q[31:16];
            mul_b  <= b_q[31:16];
            state  <= ST_ISS3;
          end
        end
        ST_ISS3: begin
          acc    <= acc + place_product(mul_p, SH_HL);
          mul_en <= 1'b0;
          mul_a  <= 16'd0;
          mul_b  <= 16'd0;
          state  <= ST_DRAIN;
        end
        ST_DRAIN: begin
          acc   <= acc + place_product(mul_p, (op_q == OP_MUL) ? SH_HL : SH_HH);
          state <= ST_FIX;
        end
        ST_FIX: begin
          acc       <= {hi_fixed, acc[31:0]};
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_data  <= (op_q == OP_MUL) ? acc[31:0] : hi_fixed;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 32'd0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mul_en    <= 1'b0;
          mul_a     <= 16'd0;
          mul_b     <= 16'd0;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_cell_sequencer.sv
// Scoreboard bench for mul_cell_sequencer: random and directed requests, reference
// product model, round-robin model, cycle-accurate response timing checks.
module tb_mul_cell_sequencer;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_src1;
  logic [32*NUM_REQ-1:0] req_src2;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic                  mul_en;
  logic [31:0]           mul_p;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;

  mul_cell_sequencer #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 16x16 multiplier cell.
  initial mul_p = 32'd0;
  always @(posedge clk) if (mul_en) mul_p <= 32'(mul_a) * 32'(mul_b);

  typedef struct {
    int          id;
    logic [31:0] data;
    int          lat;
    int          nen;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          checks = 0;
  int          failures = 0;
  int          tmo_cnt = 0;
  int          acc_cnt [NUM_REQ];
  bit          busy = 1'b0;
  int          cyc = 0;
  int          ptr_m = 0;
  bit          arb_win = 1'b0;
  bit          fin_req = 1'b0;
  bit          rnd_on = 1'b0;
  logic [31:0] cap_data;
  logic [IDW-1:0] cap_id;

  // Reference result from plain 64-bit arithmetic on the (sign-extended) operands.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = {32'd0, a};
    sb = {32'd0, b};
    if (op == 2'b10 || op == 2'b11) sa = {{32{a[31]}}, a};
    if (op == 2'b11)                sb = {{32{b[31]}}, b};
    p = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Operand halves expected on the cell for the k-th partial product.
  function automatic logic [31:0] exp_ops(input logic [31:0] a, input logic [31:0] b, input int k);
    case (k)
      0:       return {a[15:0],  b[15:0]};
      1:       return {a[15:0],  b[31:16]};
      2:       return {a[31:16], b[15:0]};
      default: return {a[31:16], b[31:16]};
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: models arbitration and timing, pops the scoreboard on responses.
  always @(negedge clk) begin
    int                 g;
    logic [NUM_REQ-1:0] exp_ready;
    exp_t               e;
    exp_t               ne;
    if (!reset_n) begin
      check("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 64'd0);
      check("rst_mul", {req_ready, mul_en, mul_a, mul_b}, 64'd0);
      exp_q.delete();
      busy  = 1'b0;
      cyc   = 0;
      ptr_m = 0;
    end else if (fin_req) begin
      check("timeouts", tmo_cnt, 0);
      check("pending", exp_q.size(), 0);
      check("arb_count", grant_log.size(), 3);
      for (int k = 0; k < grant_log.size() && k < 3; k++)
        check("arb_order", grant_log[k], (k == 1) ? 1 : 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else begin
      check("ready_onehot", ($countones(req_ready) <= 1), 1);
      if (!mul_en) check("mul_idle_zero", {mul_a, mul_b}, 64'd0);
      if (!busy) begin
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && req_valid[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("grant", req_ready, exp_ready);
        check("idle_no_rsp", rsp_valid, 0);
        if (g >= 0 && req_ready[g]) begin
          ne.id   = g;
          ne.a    = req_src1[g*32 +: 32];
          ne.b    = req_src2[g*32 +: 32];
          ne.data = ref_result(req_op[g*2 +: 2], ne.a, ne.b);
          ne.lat  = (req_op[g*2 +: 2] == 2'b00) ? 6 : 7;
          ne.nen  = (req_op[g*2 +: 2] == 2'b00) ? 3 : 4;
          exp_q.push_back(ne);
          if (arb_win) grant_log.push_back(g);
          acc_cnt[g] = acc_cnt[g] + 1;
          ptr_m = (g + 1) % NUM_REQ;
          busy  = 1'b1;
          cyc   = 0;
        end
      end else begin
        cyc++;
        e = exp_q[0];
        check("busy_no_ready", req_ready, 0);
        if (cyc < e.lat) begin
          check("rsp_early", rsp_valid, 0);
          check("mul_en_pattern", mul_en, (cyc <= e.nen));
          if (cyc <= e.nen) check("mul_ops", {mul_a, mul_b}, exp_ops(e.a, e.b, cyc - 1));
        end else if (cyc == e.lat) begin
          check("rsp_latency", rsp_valid, 1);
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", rsp_id, e.id);
          cap_data = rsp_data;
          cap_id   = rsp_id;
          if (!rsp_valid || rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end else begin
          check("rsp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, cap_id, cap_data});
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
      end
    end
  end

  // Raise a request on requester i and hold it until the monitor sees the accept.
  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int base;
    bit got;
    base = acc_cnt[i];
    got  = 1'b0;
    req_op[i*2 +: 2]    = op;
    req_src1[i*32 +: 32] = a;
    req_src2[i*32 +: 32] = b;
    req_valid[i]        = 1'b1;
    for (int t = 0; t < 60 && !got; t++) begin
      @(posedge clk);
      #1;
      if (acc_cnt[i] != base) got = 1'b1;
    end
    req_valid[i]         = 1'b0;
    req_src1[i*32 +: 32] = $urandom;
    req_src2[i*32 +: 32] = $urandom;
    req_op[i*2 +: 2]     = 2'($urandom_range(0, 3));
    if (!got) tmo_cnt++;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) tmo_cnt++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Stimulus sequence.
  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_src1  = '0;
    req_src2  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;

    // Directed operand table, back to back.
    issue(0, 2'b00, 32'h0001_0002, 32'h0003_0004);
    issue(0, 2'b01, 32'h0001_0002, 32'h0003_0004);
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(0, 2'b11, 32'h8000_0000, 32'h0000_0002);
    wait_idle();

    // Arbitration from reset with both requesters held valid.
    do_reset();
    arb_win = 1'b1;
    fork
      begin
        issue(0, 2'b01, rnd_operand(), rnd_operand());
        issue(0, 2'b11, rnd_operand(), rnd_operand());
      end
      issue(1, 2'b10, rnd_operand(), rnd_operand());
    join
    wait_idle();
    arb_win = 1'b0;

    // Backpressure: hold the response for five cycles while another request waits.
    rsp_ready = 1'b0;
    issue(0, 2'b11, rnd_operand(), rnd_operand());
    fork
      begin
        for (int t = 0; t < 30 && !rsp_valid; t++) begin
          @(posedge clk);
          #1;
        end
        if (!rsp_valid) tmo_cnt++;
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        issue(1, 2'b00, rnd_operand(), rnd_operand());
      end
    join
    wait_idle();

    // Reset during ISS2, then a clean request.
    issue(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    issue(1, 2'b11, 32'hFFFF_FFF0, 32'h0000_0010);
    wait_idle();

    // Random traffic from both requesters with random response backpressure.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    fork
      begin
        for (int n = 0; n < 14; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue(0, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
        end
      end
      begin
        for (int m = 0; m < 14; m++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue(1, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
        end
      end
    join
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_idle();

    fin_req = 1'b1;
    repeat (10) @(posedge clk);
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
